// File: rtl/traceback.sv
// Viterbi traceback: walks survivor decisions back through TB_DEPTH trellis
// columns from a start state, then emits the decoded bits oldest first.
module traceback #(
  parameter int NUM_STATE = 4,
  parameter int TB_DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 i_td_full,
  input  logic                 i_ood,
  input  logic [1:0]           i_best_state,
  input  logic [NUM_STATE-1:0] i_surv,
  output logic                 o_rd_en,
  output logic [3:0]           o_rd_addr,
  output logic                 o_bit,
  output logic                 o_bit_valid,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam logic [3:0] LAST_COL = 4'(TB_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, TRACE, OUTPUT, DONE} tb_state_e;

  tb_state_e             state;
  logic [1:0]            cur_state;
  logic [3:0]            col;
  logic [3:0]            out_cnt;
  logic                  first;
  logic [TB_DEPTH-1:0]   buffer;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cur_state   <= 2'b00;
      col         <= 4'd0;
      out_cnt     <= 4'd0;
      first       <= 1'b0;
      buffer      <= '0;
      o_rd_en     <= 1'b0;
      o_rd_addr   <= 4'd0;
      o_bit       <= 1'b0;
      o_bit_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else if (!en) begin
      state       <= IDLE;
      o_rd_en     <= 1'b0;
      o_rd_addr   <= 4'd0;
      o_bit       <= 1'b0;
      o_bit_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A terminated trellis always ends in state 0, so i_ood beats i_td_full.
          if (i_ood || i_td_full) begin
            cur_state <= i_ood ? 2'b00 : i_best_state;
            state     <= TRACE;
            o_rd_en   <= 1'b1;
            o_rd_addr <= LAST_COL;
            col       <= LAST_COL;
            first     <= 1'b1;
            o_busy    <= 1'b1;
          end
        end
        TRACE: begin
          if (o_rd_addr != 4'd0) o_rd_addr <= o_rd_addr - 4'd1;
          else                   o_rd_en   <= 1'b0;
          // Memory has one cycle of latency: the first cycle only issues a read.
          if (first) begin
            first <= 1'b0;
          end else begin
            buffer[col] <= cur_state[1];
            cur_state   <= {cur_state[0], i_surv[cur_state]};
            if (col == 4'd0) begin
              state       <= OUTPUT;
              o_bit       <= cur_state[1];
              o_bit_valid <= 1'b1;
              out_cnt     <= 4'd0;
            end else begin
              col <= col - 4'd1;
            end
          end
        end
        OUTPUT: begin
          if (out_cnt == LAST_COL) begin
            state       <= DONE;
            o_bit       <= 1'b0;
            o_bit_valid <= 1'b0;
            o_done      <= 1'b1;
          end else begin
            o_bit   <= buffer[out_cnt + 4'd1];
            out_cnt <= out_cnt + 4'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          o_done <= 1'b0;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
